dm_byte_store: RTL

- Data memory stage of the P5 pipeline (MEM stage). Sits directly downstream of the store-data select mux and consumes its 32-bit write data.
- Performs word, halfword and byte stores using byte-lane merge into a 1024-word array.
- Provides sign- or zero-extended loads to the MEM/WB register.
- Suppresses misaligned or out-of-range stores and flags them with a sticky error bit.

---
 rtl/dm_pkg.sv | 6 +
 rtl/dm_byte_merge.sv | 17 +
 rtl/dm_byte_store.sv | 64 ++++++
 3 files changed

// File: rtl/dm_pkg.sv
// dm_pkg: store/load encodings and default depth shared by the dm_byte_store data memory
package dm_pkg;
  localparam int DM_WORDS = 1024;
  localparam logic [1:0] ST_W = 2'b00, ST_H = 2'b01, ST_B = 2'b10;
  localparam logic [2:0] LD_W = 3'b000, LD_BU = 3'b001, LD_B = 3'b010, LD_HU = 3'b011, LD_H = 3'b100;
endpackage

// File: rtl/dm_byte_merge.sv
// dm_byte_merge: combinational byte-lane merge of store data into the old word (in: old_word, new_writedata, lane, store_type; out: merged)
module dm_byte_merge
  import dm_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_writedata,
  input  logic [1:0]  lane,
  input  logic [1:0]  store_type,
  output logic [31:0] merged
);
  always_comb begin
    merged = old_word;
    if (store_type == ST_W) merged = new_writedata;
    else if (store_type == ST_H) merged = lane[1] ? {new_writedata[15:0], old_word[15:0]} : {old_word[31:16], new_writedata[15:0]};
    else if (store_type == ST_B) merged[{lane, 3'b000} +: 8] = new_writedata[7:0];
  end
endmodule

// File: rtl/dm_byte_store.sv
// dm_byte_store: MEM-stage data memory, byte/half/word stores, extended async loads, sticky align_err (clk, reset, pc, addr, new_writedata, mem_write, store_type, load_type -> read_data, align_err); DM_WRITE_LOG_EN prints committed stores
module dm_byte_store #(
  parameter int DM_WORDS = dm_pkg::DM_WORDS,
  parameter int ADDR_W   = $clog2(DM_WORDS)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] addr,
  input  logic [31:0] new_writedata,
  input  logic        mem_write,
  input  logic [1:0]  store_type,
  input  logic [2:0]  load_type,
  output logic [31:0] read_data,
  output logic        align_err
);
  import dm_pkg::*;
  logic [31:0] mem [DM_WORDS];
  logic [ADDR_W-1:0] idx;
  logic [1:0] lane;
  logic in_range, mis, st_req, st_ok, st_bad;
  logic [31:0] old_word, merged, word;
  logic [15:0] half;
  logic [7:0] byt;
  assign idx      = addr[ADDR_W+1:2];
  assign lane     = addr[1:0];
  assign in_range = addr < 32'(4 * DM_WORDS);
  assign mis      = (store_type == ST_W && lane != 2'b00) || (store_type == ST_H && lane[0]);
  assign st_req   = mem_write && store_type != 2'b11;
  assign st_ok    = st_req && in_range && !mis;
  assign st_bad   = st_req && (!in_range || mis);
  assign old_word = mem[idx];
  dm_byte_merge u_merge (
    .old_word(old_word),
    .new_writedata(new_writedata),
    .lane(lane),
    .store_type(store_type),
    .merged(merged)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++) mem[i] <= '0;
      align_err <= 1'b0;
    end else begin
      if (st_ok) mem[idx] <= merged;
      if (st_bad) align_err <= 1'b1;
    end
  end
  assign word = in_range ? old_word : 32'h0;
  assign half = lane[1] ? word[31:16] : word[15:0];
  assign byt  = word[{lane, 3'b000} +: 8];
  always_comb
    read_data = load_type == LD_BU ? {24'h0, byt} :
                load_type == LD_B  ? {{24{byt[7]}}, byt} :
                load_type == LD_HU ? {16'h0, half} :
                load_type == LD_H  ? {{16{half[15]}}, half} : word;
`ifdef DM_WRITE_LOG_EN
  always_ff @(posedge clk)
    if (!reset && st_ok) $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, merged);
`else
  logic unused_pc;
  assign unused_pc = ^pc;
`endif
endmodule
